gray_count_arbiter: RTL

Round-robin scheduler that shares one modulo-MODULUS binary counter, with a Gray-coded output, among NREQ requesters. Each requester asks for a burst of len count steps. The arbiter grants one requester at a time, sequences the counter enable for exactly that many steps, and signals completion or abort. Counter state persists across grants: the counter is a shared resource, not per-requester.

---
 rtl/gray_count_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/gray_count_arbiter.sv
// ---------------------------------------------------------------------------
// gray_count_arbiter
//
// Round-robin scheduler for one shared modulo-MODULUS counter with a Gray-coded
// output. Each of NREQ requesters asks for a burst of len count steps. One
// requester is granted at a time, the counter advances once per enabled cycle
// for exactly that many steps, and the burst ends with a done pulse, plus an
// abort pulse if the owner dropped its request early. The count carries over
// from one grant to the next.
//
// Ports:
//   clk    in   rising-edge clock
//   clr    in   asynchronous active-low reset
//   en     in   global count enable; low stalls an active burst
//   req    in   [NREQ] per-requester request, held until done/abort
//   len    in   [NREQ*LENW] burst length, field i = len[i*LENW +: LENW]
//   gnt    out  [NREQ] one-hot grant, zero when idle
//   owner  out  [3] index of the current or last granted requester
//   busy   out  high while a burst is in RUN or DONE
//   Q      out  [4] Gray code of the shared count
//   cout   out  one-cycle pulse on the wrap MODULUS-1 -> 0
//   done   out  one-cycle pulse when a burst finishes
//   abort  out  one-cycle pulse with done when the burst was cut short
// ---------------------------------------------------------------------------
module gray_count_arbiter #(
  parameter int NREQ    = 4,
  parameter int MODULUS = 11,
  parameter int LENW    = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] len,
  output logic [NREQ-1:0]      gnt,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic [3:0]           Q,
  output logic                 cout,
  output logic                 done,
  output logic                 abort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(MODULUS - 1);

  state_t            r_state;
  state_t            w_state_next;

  logic [3:0]        r_count;
  logic [3:0]        r_q;
  logic              r_cout;
  logic [LENW-1:0]   r_rem;
  logic [2:0]        r_rr;
  logic [2:0]        r_owner;
  logic [NREQ-1:0]   r_gnt;
  logic              r_busy;
  logic              r_done;
  logic              r_abort;
  logic              r_abort_flag;

  // Requests padded to 8 bits so a 3-bit index never overruns the vector.
  logic [7:0]        w_req8;
  logic              w_any_req;
  logic              w_found;
  logic [3:0]        w_cand;
  logic [2:0]        w_sel;
  logic [NREQ-1:0]   w_sel_onehot;
  logic [LENW-1:0]   w_sel_len;
  logic              w_owner_req;
  logic              w_wrap;
  logic [3:0]        w_count_next;
  logic [3:0]        w_q_next;
  logic              w_last_step;

  assign w_req8      = 8'(req);
  assign w_any_req   = |req;
  assign w_owner_req = w_req8[r_owner];
  assign w_last_step = (r_rem == LENW'(1));

  // Round-robin pick: scan starting just after the last grant, wrapping.
  // r_rr < NREQ <= 8, so one conditional subtraction keeps w_cand in range.
  always_comb begin
    w_found   = 1'b0;
    w_sel     = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr} + 4'(k + 1);
      if (w_cand >= 4'(NREQ)) begin
        w_cand = w_cand - 4'(NREQ);
      end
      if (!w_found && w_req8[w_cand[2:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[2:0];
      end
    end
  end

  // Decode the winner into a one-hot grant and fetch its burst length.
  always_comb begin
    w_sel_onehot = '0;
    w_sel_len    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == 3'(i)) begin
        w_sel_onehot[i] = 1'b1;
        w_sel_len       = len[i*LENW +: LENW];
      end
    end
  end

  // Next counter value and its Gray code, so Q is registered together with
  // the count and never lags it.
  always_comb begin
    w_wrap       = (r_count == CNT_MAX);
    w_count_next = w_wrap ? 4'd0 : r_count + 4'd1;
    w_q_next     = w_count_next ^ (w_count_next >> 1);
  end

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A dropped owner request wins over a stalled enable.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_next = (w_sel_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!w_owner_req) begin
          w_state_next = S_DONE;
        end else if (en && w_last_step) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_count      <= '0;
      r_q          <= '0;
      r_cout       <= 1'b0;
      r_rem        <= '0;
      r_rr         <= 3'(NREQ - 1);
      r_owner      <= '0;
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
      r_abort_flag <= 1'b0;
    end else begin
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt        <= w_sel_onehot;
            r_owner      <= w_sel;
            r_rem        <= w_sel_len;
            r_rr         <= w_sel;
            r_busy       <= 1'b1;
            r_abort_flag <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_owner_req) begin
            r_abort_flag <= 1'b1;
          end else if (en) begin
            r_count <= w_count_next;
            r_q     <= w_q_next;
            r_cout  <= w_wrap;
            r_rem   <= r_rem - LENW'(1);
          end
        end
        S_DONE: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_abort <= r_abort_flag;
        end
        default: begin
          r_gnt  <= '0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign Q     = r_q;
  assign cout  = r_cout;
  assign done  = r_done;
  assign abort = r_abort;

endmodule
